reservation_station_mc: RTL and testbench

- Parametrised, multi-CDB reservation station feeding one execution unit (ALU or branch unit) in the out-of-order core.
- Holds up to DEPTH decoded instructions and snoops CDB_COUNT broadcast channels every cycle, including a same-cycle bypass at allocation.
- Issues the oldest ready entry through a registered valid/ready output stage.
- Supports full flush on branch mispredict and reports free capacity to the decoder.

---
 rtl/reservation_station_mc_if.sv | 57 +++++
 rtl/reservation_station_mc.sv | 194 +++++++++++++++++++
 tb/tb_reservation_station_mc.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_mc_if.sv
`default_nettype none
// =====================================================================
// reservation_station_mc_if : allocation, CDB snoop and issue bundle   | rev 1.0
// =====================================================================
interface reservation_station_mc_if #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int OP_WIDTH   = 6,
    parameter int CDB_COUNT  = 2
);
    localparam int FC_W = $clog2(DEPTH + 1);

    logic                            alloc_valid;
    logic [OP_WIDTH-1:0]             alloc_op;
    logic [ROB_WIDTH-1:0]            alloc_Qj;
    logic [ROB_WIDTH-1:0]            alloc_Qk;
    logic [DATA_WIDTH-1:0]           alloc_Vj;
    logic [DATA_WIDTH-1:0]           alloc_Vk;
    logic [DATA_WIDTH-1:0]           alloc_pc;
    logic [DATA_WIDTH-1:0]           alloc_imm;
    logic [ROB_WIDTH-1:0]            alloc_rd_rob;
    logic                            alloc_has_rd;

    logic [CDB_COUNT-1:0]            cdb_valid;
    logic [CDB_COUNT*ROB_WIDTH-1:0]  cdb_tag;
    logic [CDB_COUNT*DATA_WIDTH-1:0] cdb_data;

    logic                            has_capacity;
    logic [FC_W-1:0]                 free_count;

    logic                            issue_valid;
    logic                            issue_ready;
    logic [OP_WIDTH-1:0]             issue_op;
    logic [DATA_WIDTH-1:0]           issue_Vj;
    logic [DATA_WIDTH-1:0]           issue_Vk;
    logic [DATA_WIDTH-1:0]           issue_pc;
    logic [DATA_WIDTH-1:0]           issue_imm;
    logic [ROB_WIDTH-1:0]            issue_rob_tag;

    modport master (
        output alloc_valid, alloc_op, alloc_Qj, alloc_Qk, alloc_Vj, alloc_Vk,
               alloc_pc, alloc_imm, alloc_rd_rob, alloc_has_rd,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  has_capacity, free_count, issue_valid, issue_op, issue_Vj,
               issue_Vk, issue_pc, issue_imm, issue_rob_tag
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_Qj, alloc_Qk, alloc_Vj, alloc_Vk,
               alloc_pc, alloc_imm, alloc_rd_rob, alloc_has_rd,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output has_capacity, free_count, issue_valid, issue_op, issue_Vj,
               issue_Vk, issue_pc, issue_imm, issue_rob_tag
    );
endinterface
`default_nettype wire

// File: rtl/reservation_station_mc.sv
`default_nettype none
// =====================================================================
// reservation_station_mc : multi-CDB reservation station, oldest-ready issue | rev 1.0
// =====================================================================
module reservation_station_mc #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int OP_WIDTH   = 6,
    parameter int CDB_COUNT  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic flush,
    reservation_station_mc_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int FC_W  = $clog2(DEPTH + 1);
    localparam logic [FC_W-1:0] DEPTH_CNT = FC_W'(DEPTH);

    typedef logic [ROB_WIDTH-1:0]  tag_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    logic [DEPTH-1:0]            busy_q;
    logic [OP_WIDTH-1:0]         op_q  [DEPTH];
    tag_t                        qj_q  [DEPTH];
    tag_t                        qk_q  [DEPTH];
    tag_t                        rob_q [DEPTH];
    data_t                       vj_q  [DEPTH];
    data_t                       vk_q  [DEPTH];
    data_t                       pc_q  [DEPTH];
    data_t                       imm_q [DEPTH];
    // older_q[i][j] set: entry j was allocated before entry i and is still live
    logic [DEPTH-1:0][DEPTH-1:0] older_q;
    logic [FC_W-1:0]             free_count_q;
    logic [FC_W-1:0]             free_count_d;

    logic                        issue_valid_q;
    logic [OP_WIDTH-1:0]         issue_op_q;
    data_t                       issue_vj_q;
    data_t                       issue_vk_q;
    data_t                       issue_pc_q;
    data_t                       issue_imm_q;
    tag_t                        issue_rob_q;

    logic [DEPTH-1:0]            w_ready;
    logic [DEPTH-1:0]            w_sel_oh;
    logic [IDX_W-1:0]            w_sel_idx;
    logic [IDX_W-1:0]            w_free_idx;
    logic                        w_has_cap;
    logic                        w_alloc;
    logic                        w_load;
    logic [DATA_WIDTH:0]         w_alloc_j;
    logic [DATA_WIDTH:0]         w_alloc_k;
    logic [DATA_WIDTH:0]         w_wake_j [DEPTH];
    logic [DATA_WIDTH:0]         w_wake_k [DEPTH];

    // Returns {hit, value}; iterating downwards lets the lowest channel win.
    function automatic logic [DATA_WIDTH:0] f_snoop(
        input tag_t                            tag,
        input data_t                           val,
        input logic [CDB_COUNT-1:0]            cv,
        input logic [CDB_COUNT*ROB_WIDTH-1:0]  ct,
        input logic [CDB_COUNT*DATA_WIDTH-1:0] cd
    );
        logic [DATA_WIDTH:0] r;
        r = {1'b0, val};
        for (int c = CDB_COUNT - 1; c >= 0; c--) begin
            if (cv[c] && (tag != '0) && (ct[c*ROB_WIDTH +: ROB_WIDTH] == tag))
                r = {1'b1, cd[c*DATA_WIDTH +: DATA_WIDTH]};
        end
        return r;
    endfunction

    always_comb begin
        w_ready    = '0;
        w_sel_oh   = '0;
        w_sel_idx  = '0;
        w_free_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            w_ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ready[i] && ((older_q[i] & w_ready) == '0)) begin
                w_sel_oh[i] = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!busy_q[i]) w_free_idx = IDX_W'(i);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wake_j[i] = f_snoop(qj_q[i], vj_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            w_wake_k[i] = f_snoop(qk_q[i], vk_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
    end

    assign w_alloc_j    = f_snoop(bus.alloc_Qj, bus.alloc_Vj, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    assign w_alloc_k    = f_snoop(bus.alloc_Qk, bus.alloc_Vk, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    assign w_has_cap    = (free_count_q != '0);
    assign w_alloc      = bus.alloc_valid & w_has_cap & ena & ~flush;
    assign w_load       = ena & ~flush & (|w_ready) & (~issue_valid_q | bus.issue_ready);
    assign free_count_d = free_count_q - FC_W'(w_alloc) + FC_W'(w_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            older_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                rob_q[i] <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                pc_q[i]  <= '0;
                imm_q[i] <= '0;
            end
        end else if (flush) begin
            busy_q  <= '0;
            older_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wake_j[i][DATA_WIDTH]) begin
                    qj_q[i] <= '0;
                    vj_q[i] <= w_wake_j[i][DATA_WIDTH-1:0];
                end
                if (w_wake_k[i][DATA_WIDTH]) begin
                    qk_q[i] <= '0;
                    vk_q[i] <= w_wake_k[i][DATA_WIDTH-1:0];
                end
                if (w_load && w_sel_oh[i])
                    busy_q[i] <= 1'b0;
                // The new entry is younger than every entry surviving this edge.
                if (w_alloc && (w_free_idx == IDX_W'(i))) begin
                    busy_q[i]  <= 1'b1;
                    op_q[i]    <= bus.alloc_op;
                    qj_q[i]    <= w_alloc_j[DATA_WIDTH] ? '0 : bus.alloc_Qj;
                    qk_q[i]    <= w_alloc_k[DATA_WIDTH] ? '0 : bus.alloc_Qk;
                    vj_q[i]    <= w_alloc_j[DATA_WIDTH-1:0];
                    vk_q[i]    <= w_alloc_k[DATA_WIDTH-1:0];
                    pc_q[i]    <= bus.alloc_pc;
                    imm_q[i]   <= bus.alloc_imm;
                    rob_q[i]   <= bus.alloc_has_rd ? bus.alloc_rd_rob : '0;
                    older_q[i] <= busy_q & ~(w_load ? w_sel_oh : '0);
                end
                if (w_alloc)
                    older_q[i][w_free_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_count_q  <= DEPTH_CNT;
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_vj_q    <= '0;
            issue_vk_q    <= '0;
            issue_pc_q    <= '0;
            issue_imm_q   <= '0;
            issue_rob_q   <= '0;
        end else if (flush) begin
            free_count_q  <= DEPTH_CNT;
            issue_valid_q <= 1'b0;
        end else begin
            free_count_q <= free_count_d;
            if (w_load) begin
                issue_valid_q <= 1'b1;
                issue_op_q    <= op_q[w_sel_idx];
                issue_vj_q    <= vj_q[w_sel_idx];
                issue_vk_q    <= vk_q[w_sel_idx];
                issue_pc_q    <= pc_q[w_sel_idx];
                issue_imm_q   <= imm_q[w_sel_idx];
                issue_rob_q   <= rob_q[w_sel_idx];
            end else if (issue_valid_q && bus.issue_ready) begin
                issue_valid_q <= 1'b0;
            end
        end
    end

    assign bus.has_capacity  = w_has_cap;
    assign bus.free_count    = free_count_q;
    assign bus.issue_valid   = issue_valid_q;
    assign bus.issue_op      = issue_op_q;
    assign bus.issue_Vj      = issue_vj_q;
    assign bus.issue_Vk      = issue_vk_q;
    assign bus.issue_pc      = issue_pc_q;
    assign bus.issue_imm     = issue_imm_q;
    assign bus.issue_rob_tag = issue_rob_q;
endmodule
`default_nettype wire

// File: tb/tb_reservation_station_mc.sv
`default_nettype none
// =====================================================================
// tb_reservation_station_mc : directed + random bench against an age-ordered queue model | rev 1.0
// =====================================================================
module tb_reservation_station_mc;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int RW    = 4;
    localparam int OW    = 6;
    localparam int CC    = 2;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic flush;

    reservation_station_mc_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ROB_WIDTH(RW),
                                .OP_WIDTH(OW), .CDB_COUNT(CC)) bus ();

    reservation_station_mc #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ROB_WIDTH(RW),
                             .OP_WIDTH(OW), .CDB_COUNT(CC)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [RW-1:0] qj;
        logic [RW-1:0] qk;
        logic [DW-1:0] vj;
        logic [DW-1:0] vk;
        logic [DW-1:0] pc;
        logic [DW-1:0] imm;
        logic [RW-1:0] rob;
    } ent_t;

    ent_t rs[$];   // waiting entries, oldest first
    ent_t iss;
    bit   iv;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic ent_t wake_ent(input ent_t e);
        logic [RW-1:0] t;
        for (int c = 0; c < CC; c++) begin
            t = bus.cdb_tag[c*RW +: RW];
            if (bus.cdb_valid[c]) begin
                if (e.qj != 0 && e.qj == t) begin e.qj = 0; e.vj = bus.cdb_data[c*DW +: DW]; end
                if (e.qk != 0 && e.qk == t) begin e.qk = 0; e.vk = bus.cdb_data[c*DW +: DW]; end
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        rs.delete();
        iv  = 0;
        iss = '0;
    endtask

    task automatic model_edge();
        int   idx;
        bit   can_alloc;
        ent_t e;
        if (flush) begin
            rs.delete();
            iv = 0;
            return;
        end
        can_alloc = rs.size() < DEPTH;
        idx = -1;
        foreach (rs[i]) if (idx < 0 && rs[i].qj == 0 && rs[i].qk == 0) idx = i;
        if (ena && idx >= 0 && (!iv || bus.issue_ready)) begin
            iss = rs[idx];
            rs.delete(idx);
            iv = 1;
        end else if (iv && bus.issue_ready) begin
            iv = 0;
        end
        foreach (rs[i]) rs[i] = wake_ent(rs[i]);
        if (bus.alloc_valid && ena && can_alloc) begin
            e.op  = bus.alloc_op;   e.qj  = bus.alloc_Qj; e.qk = bus.alloc_Qk;
            e.vj  = bus.alloc_Vj;   e.vk  = bus.alloc_Vk; e.pc = bus.alloc_pc;
            e.imm = bus.alloc_imm;
            e.rob = bus.alloc_has_rd ? bus.alloc_rd_rob : '0;
            rs.push_back(wake_ent(e));
        end
    endtask

    task automatic compare_all();
        check("issue_valid", bus.issue_valid, iv);
        if (iv) begin
            check("issue_op",  bus.issue_op,      iss.op);
            check("issue_Vj",  bus.issue_Vj,      iss.vj);
            check("issue_Vk",  bus.issue_Vk,      iss.vk);
            check("issue_pc",  bus.issue_pc,      iss.pc);
            check("issue_imm", bus.issue_imm,     iss.imm);
            check("issue_rob", bus.issue_rob_tag, iss.rob);
        end
        check("free_count",   bus.free_count,   DEPTH - rs.size());
        check("has_capacity", bus.has_capacity, rs.size() < DEPTH);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.issue_valid,   0);
        check({tag, "_free"},  bus.free_count,    DEPTH);
        check({tag, "_cap"},   bus.has_capacity,  1);
        check({tag, "_data"},  {bus.issue_op, bus.issue_Vj, bus.issue_Vk, bus.issue_rob_tag}, 0);
        check({tag, "_pcimm"}, {bus.issue_pc, bus.issue_imm}, 0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        bus.alloc_valid = 0;
        bus.cdb_valid   = '0;
        bus.cdb_tag     = '0;
        bus.cdb_data    = '0;
        flush           = 0;
    endtask

    task automatic alloc(input int op, input int qj, input int qk, input int vj,
                         input int vk, input int rob);
        bus.alloc_valid  = 1;
        bus.alloc_op     = OW'(op);
        bus.alloc_Qj     = RW'(qj);
        bus.alloc_Qk     = RW'(qk);
        bus.alloc_Vj     = DW'(vj);
        bus.alloc_Vk     = DW'(vk);
        bus.alloc_pc     = DW'(32'h1000 + rob * 4);
        bus.alloc_imm    = DW'(rob * 3);
        bus.alloc_rd_rob = RW'(rob);
        bus.alloc_has_rd = 1;
    endtask

    task automatic cdb(input int ch, input int tag, input int data);
        bus.cdb_valid[ch]          = 1'b1;
        bus.cdb_tag[ch*RW +: RW]   = RW'(tag);
        bus.cdb_data[ch*DW +: DW]  = DW'(data);
    endtask

    logic [RW-1:0] held_rob;
    logic [DW-1:0] held_vj;

    initial begin
        rst = 1; ena = 0; idle();
        bus.issue_ready = 0;
        bus.alloc_op = '0; bus.alloc_Qj = '0; bus.alloc_Qk = '0; bus.alloc_Vj = '0;
        bus.alloc_Vk = '0; bus.alloc_pc = '0; bus.alloc_imm = '0; bus.alloc_rd_rob = '0;
        bus.alloc_has_rd = 0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 0; ena = 1; bus.issue_ready = 1;

        // single ready instruction, 2-edge latency
        alloc(5, 0, 0, 3, 4, 2); step();
        check("t1_not_yet", bus.issue_valid, 0);
        idle(); step();
        check("t1_valid", bus.issue_valid, 1);
        check("t1_vj", bus.issue_Vj, 3);
        check("t1_vk", bus.issue_Vk, 4);
        check("t1_rob", bus.issue_rob_tag, 2);
        check("t1_free", bus.free_count, 8);
        idle(); step();

        // out-of-order wakeup across channels
        alloc(1, 7, 0, 0, 1, 10); step();
        alloc(2, 0, 9, 2, 0, 11); step();
        idle(); cdb(1, 9, 32'h55); step();
        idle(); cdb(0, 7, 32'h11); step();
        check("t2_b_first", bus.issue_rob_tag, 11);
        check("t2_b_vk", bus.issue_Vk, 32'h55);
        idle(); step();
        check("t2_a_next", bus.issue_rob_tag, 10);
        check("t2_a_vj", bus.issue_Vj, 32'h11);
        idle(); step();

        // age beats slot index: D lands in a lower slot than the older C
        alloc(3, 0, 0, 1, 1, 12); step();
        alloc(4, 3, 0, 0, 5, 13); step();
        alloc(6, 3, 0, 0, 6, 14); step();
        idle(); cdb(1, 3, 32'h77); step();
        idle(); step();
        check("t3_c_first", bus.issue_rob_tag, 13);
        check("t3_c_vj", bus.issue_Vj, 32'h77);
        idle(); step();
        check("t3_d_next", bus.issue_rob_tag, 14);
        check("t3_d_vj", bus.issue_Vj, 32'h77);
        idle(); step();

        // allocation bypass from same-cycle CDB
        alloc(7, 6, 0, 0, 9, 5); cdb(0, 6, 32'hABCD); step();
        idle(); step();
        check("t4_bypass_valid", bus.issue_valid, 1);
        check("t4_bypass_vj", bus.issue_Vj, 32'hABCD);
        idle(); step();

        // fill to full with the consumer stalled, then drain in age order
        bus.issue_ready = 0;
        for (int k = 0; k < 12 && rs.size() < DEPTH; k++) begin
            alloc(8, 0, 0, k, k + 100, k + 1); step();
        end
        check("t5_full_cap", bus.has_capacity, 0);
        check("t5_full_free", bus.free_count, 0);
        alloc(9, 0, 0, 99, 99, 15); step();
        check("t5_ninth_ignored", bus.free_count, 0);
        idle();
        held_rob = bus.issue_rob_tag;
        held_vj  = bus.issue_Vj;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t5_stall_rob", bus.issue_rob_tag, held_rob);
            check("t5_stall_vj", bus.issue_Vj, held_vj);
        end
        bus.issue_ready = 1;
        for (int k = 0; k < 11; k++) step();
        check("t5_drained", bus.free_count, 8);

        // flush wins over allocation and a held output
        bus.issue_ready = 0;
        for (int k = 0; k < 5; k++) begin alloc(10, 0, 0, k, k, k + 1); step(); end
        alloc(11, 0, 0, 1, 1, 7); flush = 1; step();
        check("t6_flush_valid", bus.issue_valid, 0);
        check("t6_flush_free", bus.free_count, 8);
        idle(); step();
        check("t6_alloc_dropped", bus.free_count, 8);

        // asynchronous reset mid-operation
        bus.issue_ready = 1;
        alloc(12, 0, 0, 1, 2, 3); step();
        alloc(13, 4, 0, 1, 2, 4); step();
        idle();
        #2 rst = 1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst = 0;

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            idle();
            ena             = ($urandom_range(0, 9) != 0);
            flush           = ($urandom_range(0, 59) == 0);
            bus.issue_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6) begin
                alloc($urandom_range(0, 63),
                      $urandom_range(0, 1) ? 0 : $urandom_range(1, 15),
                      $urandom_range(0, 1) ? 0 : $urandom_range(1, 15),
                      $urandom, $urandom, $urandom_range(0, 15));
                bus.alloc_pc     = $urandom;
                bus.alloc_has_rd = ($urandom_range(0, 3) != 0);
            end
            for (int c = 0; c < CC; c++)
                if ($urandom_range(0, 1) != 0) cdb(c, $urandom_range(1, 15), $urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
